// File: rtl/imme_operand_stage.sv
// Operand-B selection stage for the execute pipeline.
// The stage forms the ALU operand B from the register-file B read data or the
// raw immediate, which can be sign-extended, zero-extended or placed in the
// upper bits. It also carries the store data and the branch offset.
// Buffering is a two-entry skid buffer: a main register that drives the
// outputs, plus one skid register. Because in_ready depends only on whether
// the skid register is occupied, there is no combinational path from
// out_ready to in_ready.
module imme_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 17,
  parameter int PCOFF_W = 12,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  data_readRegB,
  input  logic [IMM_W-1:0]   immediate,
  input  logic [1:0]         imm_mode,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  imme_to_ALU,
  output logic [DATA_W-1:0]  imme_to_data_dmem,
  output logic [PCOFF_W-1:0] N_to_pc,
  output logic [CNT_W-1:0]   stall_cnt
);

  // Build the ALU operand for the given mode.
  // The widening is done bit by bit, so DATA_W == IMM_W stays legal
  // (the upper fill range is then simply empty).
  function automatic logic [DATA_W-1:0] form_operand(
    input logic [1:0]        mode,
    input logic [DATA_W-1:0] regb,
    input logic [IMM_W-1:0]  imm
  );
    logic [DATA_W-1:0] zext_s;
    logic [DATA_W-1:0] sext_s;
    logic [DATA_W-1:0] upper_s;
    logic [DATA_W-1:0] res_s;
    zext_s = DATA_W'(imm);
    sext_s = zext_s;
    for (int i = IMM_W; i < DATA_W; i++) begin
      sext_s[i] = imm[IMM_W-1];
    end
    upper_s = zext_s << (DATA_W - IMM_W);
    case (mode)
      2'b00:   res_s = regb;
      2'b01:   res_s = sext_s;
      2'b10:   res_s = zext_s;
      2'b11:   res_s = upper_s;
      default: res_s = regb;
    endcase
    return res_s;
  endfunction

  // Main (output) register.
  logic               main_valid_r;
  logic [DATA_W-1:0]  main_alu_r;
  logic [DATA_W-1:0]  main_dmem_r;
  logic [PCOFF_W-1:0] main_pc_r;

  // Skid register.
  logic               skid_valid_r;
  logic [DATA_W-1:0]  skid_alu_r;
  logic [DATA_W-1:0]  skid_dmem_r;
  logic [PCOFF_W-1:0] skid_pc_r;

  logic [CNT_W-1:0]   stall_cnt_r;

  // Next-state values.
  logic               main_valid_s;
  logic [DATA_W-1:0]  main_alu_s;
  logic [DATA_W-1:0]  main_dmem_s;
  logic [PCOFF_W-1:0] main_pc_s;
  logic               skid_valid_s;
  logic [DATA_W-1:0]  skid_alu_s;
  logic [DATA_W-1:0]  skid_dmem_s;
  logic [PCOFF_W-1:0] skid_pc_s;
  logic [CNT_W-1:0]   stall_cnt_s;

  // Handshake and incoming-operand decode.
  logic               in_xfer_s;
  logic               out_xfer_s;
  logic               main_free_s;
  logic [DATA_W-1:0]  in_alu_s;
  logic [PCOFF_W-1:0] in_pc_s;

  assign in_ready    = ~skid_valid_r;
  assign in_xfer_s   = in_valid & ~skid_valid_r & ~flush;
  assign out_xfer_s  = main_valid_r & out_ready;
  // The main register can take new contents if it is empty or is draining this edge.
  assign main_free_s = out_xfer_s | ~main_valid_r;
  assign in_alu_s    = form_operand(imm_mode, data_readRegB, immediate);
  assign in_pc_s     = immediate[PCOFF_W-1:0];

  // Next-state logic for the buffer.
  // Flush clears only the valid flags. The data registers keep their values.
  always_comb begin
    main_valid_s = main_valid_r;
    main_alu_s   = main_alu_r;
    main_dmem_s  = main_dmem_r;
    main_pc_s    = main_pc_r;
    skid_valid_s = skid_valid_r;
    skid_alu_s   = skid_alu_r;
    skid_dmem_s  = skid_dmem_r;
    skid_pc_s    = skid_pc_r;
    if (flush) begin
      main_valid_s = 1'b0;
      skid_valid_s = 1'b0;
    end else if (main_free_s) begin
      if (skid_valid_r) begin
        // Refill from the skid register. The input is blocked this cycle because in_ready is 0.
        main_valid_s = 1'b1;
        main_alu_s   = skid_alu_r;
        main_dmem_s  = skid_dmem_r;
        main_pc_s    = skid_pc_r;
        skid_valid_s = 1'b0;
      end else if (in_xfer_s) begin
        main_valid_s = 1'b1;
        main_alu_s   = in_alu_s;
        main_dmem_s  = data_readRegB;
        main_pc_s    = in_pc_s;
      end else begin
        main_valid_s = 1'b0;
      end
    end else begin
      // The main register is holding under backpressure, so a new operand goes into the skid register.
      if (in_xfer_s) begin
        skid_valid_s = 1'b1;
        skid_alu_s   = in_alu_s;
        skid_dmem_s  = data_readRegB;
        skid_pc_s    = in_pc_s;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end
  end

  // Saturating count of cycles spent stalled by downstream. Flush does not affect it.
  always_comb begin
    stall_cnt_s = stall_cnt_r;
    if (main_valid_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_s = stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_s = stall_cnt_r;
    end
  end

  // State registers. Reset clears everything at once, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      main_alu_r   <= {DATA_W{1'b0}};
      main_dmem_r  <= {DATA_W{1'b0}};
      main_pc_r    <= {PCOFF_W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_alu_r   <= {DATA_W{1'b0}};
      skid_dmem_r  <= {DATA_W{1'b0}};
      skid_pc_r    <= {PCOFF_W{1'b0}};
      stall_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      main_valid_r <= main_valid_s;
      main_alu_r   <= main_alu_s;
      main_dmem_r  <= main_dmem_s;
      main_pc_r    <= main_pc_s;
      skid_valid_r <= skid_valid_s;
      skid_alu_r   <= skid_alu_s;
      skid_dmem_r  <= skid_dmem_s;
      skid_pc_r    <= skid_pc_s;
      stall_cnt_r  <= stall_cnt_s;
    end
  end

  assign out_valid         = main_valid_r;
  assign imme_to_ALU       = main_alu_r;
  assign imme_to_data_dmem = main_dmem_r;
  assign N_to_pc           = main_pc_r;
  assign stall_cnt         = stall_cnt_r;

endmodule

// File: tb/tb_imme_operand_stage.sv
// Self-checking bench for imme_operand_stage.
// It has three parts:
//  - a table of single-transfer vectors;
//  - hand-written sequences for backpressure, flush, reset and saturation;
//  - a randomized run checked against a queue-based reference model.
module tb_imme_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_readRegB;
  logic [16:0] immediate;
  logic [1:0]  imm_mode;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imme_to_ALU;
  logic [31:0] imme_to_data_dmem;
  logic [11:0] N_to_pc;
  logic [7:0]  stall_cnt;

  int total;
  int bad;

  imme_operand_stage #(
    .DATA_W(32), .IMM_W(17), .PCOFF_W(12), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_readRegB(data_readRegB), .immediate(immediate), .imm_mode(imm_mode),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .imme_to_ALU(imme_to_ALU), .imme_to_data_dmem(imme_to_data_dmem),
    .N_to_pc(N_to_pc), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] regb;
    logic [16:0] imm;
    logic [31:0] exp_alu;
    logic [31:0] exp_dmem;
    logic [11:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] dmem;
    logic [11:0] pc;
  } op_t;

  vec_t vecs[7];
  op_t  model_q[$];
  int   stall_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] m, input logic [31:0] rb, input logic [16:0] imm);
    in_valid      = 1'b1;
    imm_mode      = m;
    data_readRegB = rb;
    immediate     = imm;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #2;
    rst_n     = 1'b1;
  endtask

  // Reference operand, computed arithmetically from the mode rules.
  function automatic logic [31:0] ref_op(input logic [1:0] m, input logic [31:0] rb, input logic [16:0] imm);
    longint v;
    v = longint'(imm);
    case (m)
      2'b00: v = longint'(rb);
      2'b01: if (imm >= 17'h10000) v = v - 64'sd131072;
      2'b10: v = v;
      default: v = v * 64'sd32768;
    endcase
    return v[31:0];
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    imm_mode = 2'b00;
    data_readRegB = 32'h0;
    immediate = 17'h0;

    vecs[0] = '{2'b01, 32'h12345678, 17'h10005, 32'hFFFF0005, 32'h12345678, 12'h005};
    vecs[1] = '{2'b10, 32'h00000000, 17'h10005, 32'h00010005, 32'h00000000, 12'h005};
    vecs[2] = '{2'b11, 32'hA5A5A5A5, 17'h00001, 32'h00008000, 32'hA5A5A5A5, 12'h001};
    vecs[3] = '{2'b00, 32'hDEADBEEF, 17'h1FFFF, 32'hDEADBEEF, 32'hDEADBEEF, 12'hFFF};
    vecs[4] = '{2'b01, 32'h00000001, 17'h0FFFF, 32'h0000FFFF, 32'h00000001, 12'hFFF};
    vecs[5] = '{2'b11, 32'h00000002, 17'h1FFFF, 32'hFFFF8000, 32'h00000002, 12'hFFF};
    vecs[6] = '{2'b10, 32'h00000003, 17'h1FFFF, 32'h0001FFFF, 32'h00000003, 12'hFFF};

    // Reset state, checked while rst_n is held low.
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_alu", 64'(imme_to_ALU), 64'd0);
    chk("rst_dmem", 64'(imme_to_data_dmem), 64'd0);
    chk("rst_pc", 64'(N_to_pc), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    rst_n = 1'b1;

    // Table vectors, streamed back-to-back with out_ready=1.
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      offer(vecs[i].mode, vecs[i].regb, vecs[i].imm);
      tick();
      chk("vec_valid", 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_alu", i), 64'(imme_to_ALU), 64'(vecs[i].exp_alu));
      chk($sformatf("vec%0d_dmem", i), 64'(imme_to_data_dmem), 64'(vecs[i].exp_dmem));
      chk($sformatf("vec%0d_pc", i), 64'(N_to_pc), 64'(vecs[i].exp_pc));
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: A, B, C offered while out_ready=0.
    do_reset();
    out_ready = 1'b0;
    offer(2'b00, 32'hAAAA0001, 17'h0);
    tick();
    chk("bp_a_valid", 64'(out_valid), 64'd1);
    chk("bp_a_alu", 64'(imme_to_ALU), 64'hAAAA0001);
    offer(2'b00, 32'hBBBB0002, 17'h0);
    tick();
    chk("bp_b_in_ready", 64'(in_ready), 64'd0);
    chk("bp_b_hold_a", 64'(imme_to_ALU), 64'hAAAA0001);
    chk("bp_stall1", 64'(stall_cnt), 64'd1);
    offer(2'b00, 32'hCCCC0003, 17'h0);
    tick();
    chk("bp_c_in_ready", 64'(in_ready), 64'd0);
    chk("bp_c_hold_a", 64'(imme_to_ALU), 64'hAAAA0001);
    chk("bp_stall2", 64'(stall_cnt), 64'd2);
    out_ready = 1'b1;
    tick();
    chk("bp_out_b", 64'(imme_to_ALU), 64'hBBBB0002);
    chk("bp_out_b_valid", 64'(out_valid), 64'd1);
    chk("bp_stall_hold", 64'(stall_cnt), 64'd2);
    tick();
    chk("bp_out_c", 64'(imme_to_ALU), 64'hCCCC0003);
    chk("bp_out_c_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush with main and skid both full and an input offered at the same edge.
    do_reset();
    out_ready = 1'b0;
    offer(2'b00, 32'h11110001, 17'h0);
    tick();
    offer(2'b00, 32'h22220002, 17'h0);
    tick();
    chk("fl_full", 64'(in_ready), 64'd0);
    chk("fl_stall_pre", 64'(stall_cnt), 64'd1);
    out_ready = 1'b1;
    flush = 1'b1;
    offer(2'b00, 32'h33330003, 17'h0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_stall", 64'(stall_cnt), 64'd1);
    chk("fl_data_kept", 64'(imme_to_ALU), 64'h11110001);
    tick();
    chk("fl_input_absent", 64'(out_valid), 64'd0);

    // Asynchronous reset with two operands buffered.
    out_ready = 1'b0;
    offer(2'b00, 32'h44440004, 17'h0);
    tick();
    offer(2'b00, 32'h55550005, 17'h0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("ar_pre_stall", 64'(stall_cnt), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_stall", 64'(stall_cnt), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    offer(2'b10, 32'h0, 17'h00042);
    tick();
    chk("ar_first_xfer", 64'(out_valid), 64'd1);
    chk("ar_first_alu", 64'(imme_to_ALU), 64'h00000042);
    in_valid = 1'b0;

    // Saturation after 300 stalled cycles.
    for (int i = 0; i < 300; i++) tick();
    chk("sat_stall", 64'(stall_cnt), 64'd255);
    chk("sat_hold", 64'(imme_to_ALU), 64'h00000042);

    // Randomized run against the queue model.
    do_reset();
    stall_m = 0;
    model_q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      op_t item;
      bit  fire_in;
      bit  fire_out;
      bit  stall_inc;
      bit  fl;
      in_valid      = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      imm_mode      = 2'($urandom_range(0, 3));
      data_readRegB = $urandom;
      immediate     = 17'($urandom);
      item.alu  = ref_op(imm_mode, data_readRegB, immediate);
      item.dmem = data_readRegB;
      item.pc   = immediate[11:0];
      fl        = flush;
      fire_in   = in_valid && (model_q.size() < 2) && !flush;
      fire_out  = (model_q.size() > 0) && out_ready;
      stall_inc = (model_q.size() > 0) && !out_ready;
      tick();
      if (stall_inc && stall_m < 255) stall_m++;
      if (fl) begin
        model_q.delete();
      end else begin
        if (fire_out) void'(model_q.pop_front());
        if (fire_in) model_q.push_back(item);
      end
      chk("rnd_out_valid", 64'(out_valid), 64'(model_q.size() > 0));
      chk("rnd_in_ready", 64'(in_ready), 64'(model_q.size() < 2));
      chk("rnd_stall", 64'(stall_cnt), 64'(stall_m));
      if (model_q.size() > 0) begin
        chk("rnd_alu", 64'(imme_to_ALU), 64'(model_q[0].alu));
        chk("rnd_dmem", 64'(imme_to_data_dmem), 64'(model_q[0].dmem));
        chk("rnd_pc", 64'(N_to_pc), 64'(model_q[0].pc));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imme_operand_stage.md
IMME_OPERAND_STAGE -- requirements
Module: imme_operand_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with clock and reset ports named as the codebase does (clk, rst_n).
REQ-002 The block SHALL provide these parameters (name, default, meaning):
- DATA_W, 32, operand width; legal only when DATA_W >= IMM_W.
- IMM_W, 17, raw immediate width.
- PCOFF_W, 12, branch offset width; legal only when PCOFF_W <= IMM_W.
- CNT_W, 8, stall counter width.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, upstream has an operand.
- in_ready, out, 1, stage can accept.
- data_readRegB, in, DATA_W, register file B read data.
- immediate, in, IMM_W, raw immediate.
- imm_mode, in, 2, operand-B source select.
- flush, in, 1, synchronous pipeline kill.
- out_valid, out, 1, output holds an operand.
- out_ready, in, 1, downstream accepts.
- imme_to_ALU, out, DATA_W, ALU operand B.
- imme_to_data_dmem, out, DATA_W, store data.
- N_to_pc, out, PCOFF_W, branch offset.
- stall_cnt, out, CNT_W, backpressure cycle count.

Function
REQ-004 imm_mode SHALL select the ALU operand as follows: 00 = data_readRegB; 01 = immediate sign-extended (bit IMM_W-1 replicated into every upper bit); 10 = immediate zero-extended; 11 = immediate placed in bits [DATA_W-1:DATA_W-IMM_W], with the low bits zero.
REQ-005 imme_to_data_dmem SHALL equal the data_readRegB value captured with the same transfer, regardless of imm_mode.
REQ-006 N_to_pc SHALL equal immediate[PCOFF_W-1:0] captured with the same transfer, regardless of imm_mode.
REQ-007 An input transfer SHALL occur on a rising edge where in_valid=1, in_ready=1 and flush=0.
REQ-008 An output transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-009 Storage SHALL be a main register driving the outputs plus one skid register; no other buffering.
REQ-010 Latency SHALL be 1 cycle: data accepted at edge N SHALL appear on the outputs with out_valid=1 after edge N when the main register is empty or is being drained at edge N.
REQ-011 If an input transfer occurs while the main register is valid and not draining, the data SHALL be written to the skid register.
REQ-012 in_ready SHALL equal NOT skid_valid; it is purely registered-state derived, with no combinational path from out_ready.
REQ-013 When the main register drains and the skid register is valid, the main register SHALL load the skid contents and the skid SHALL clear on the same edge. A simultaneous input transfer is impossible because in_ready=0.
REQ-014 Operands SHALL leave in acceptance order; no drop or duplication occurs except by flush.
REQ-015 While out_valid=1 and out_ready=0, the outputs SHALL hold stable.
REQ-016 flush=1 at an edge SHALL clear out_valid and skid_valid, and SHALL discard any concurrent input. Flush has priority over every transfer.
REQ-017 Data registers SHALL be left unchanged by flush; only the valid flags clear.
REQ-018 stall_cnt SHALL increment by 1 at every edge where out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and be unaffected by flush.
REQ-019 All datapath arithmetic SHALL be width-exact to DATA_W, with no truncation of the immediate for any legal parameter set.

Reset
REQ-020 While rst_n=0, the block SHALL hold: out_valid=0, skid_valid=0, in_ready=1, imme_to_ALU=0, imme_to_data_dmem=0, N_to_pc=0, stall_cnt=0.
REQ-021 Reset assertion mid-operation SHALL discard all buffered operands immediately, without waiting for clk.
REQ-022 After rst_n deasserts, the first input transfer SHALL be possible on the first rising clk edge.

Verification
REQ-023 The bench SHALL check sign extension: imm_mode=01, immediate=17'h10005, out_ready=1 -> next cycle imme_to_ALU=32'hFFFF0005, N_to_pc=12'h005.
REQ-024 The bench SHALL check zero extension and upper placement:
- imm_mode=10, immediate=17'h10005 -> imme_to_ALU=32'h00010005.
- imm_mode=11, immediate=17'h00001 -> imme_to_ALU=32'h00008000.
REQ-025 The bench SHALL check register select: imm_mode=00, data_readRegB=32'hDEADBEEF, immediate=17'h1FFFF -> imme_to_ALU=imme_to_data_dmem=32'hDEADBEEF.
REQ-026 The bench SHALL check backpressure:
- Stimulus: out_ready=0 while operands A, B, C are offered.
- Required: A on the outputs, B in skid, in_ready=0, C not accepted, stall_cnt increments per cycle.
- Then out_ready=1: A, B, C exit in order on consecutive cycles.
REQ-027 The bench SHALL check flush: main and skid both full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, the offered input absent, stall_cnt unchanged.
REQ-028 The bench SHALL check reset and saturation:
- rst_n pulsed low between clk edges with two operands buffered -> out_valid=0 and stall_cnt=0 immediately.
- 300 stall cycles with CNT_W=8 -> stall_cnt=255.
